// File: rtl/mem_port_arbiter.sv
// Shares one single-port, fixed-latency memory between instruction fetch and load/store.
// One transaction in flight at a time: IDLE grant -> ISSUE strobe -> WAIT latency -> RESP pulse.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int LATENCY  = 2,
    parameter int ARB_MODE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    input  logic          ls_req_i,
    input  logic          ls_we_i,
    input  logic [3:0]    ls_be_i,
    input  logic [AW-1:0] ls_addr_i,
    input  logic [31:0]   ls_wdata_i,
    output logic          ls_gnt_o,
    output logic          ls_rvalid_o,
    output logic [31:0]   rdata_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [3:0]    mem_be_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i,
    output logic          busy_o
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("mem_port_arbiter: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    owner_t        r_owner;
    owner_t        r_last_owner;
    logic          w_if_win;
    logic          w_ls_win;

    logic          r_mem_we;
    logic [3:0]    r_mem_be;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_mem_wdata;

    // Grants are only offered in IDLE and never while reset is held, so a
    // requester can't see a grant that the state register will then discard.
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_if_win = 1'b0;
        w_ls_win = 1'b0;
        if (r_state == S_IDLE && !reset) begin
            if (if_req_i && ls_req_i) begin
                if (ARB_MODE == 1 || r_last_owner == OWN_IF) w_ls_win = 1'b1;
                else                                        w_if_win = 1'b1;
            end else begin
                w_if_win = if_req_i;
                w_ls_win = ls_req_i;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_if_win || w_ls_win) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                w_cnt_nxt   = 4'd1;
                w_state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt == LAT_M1) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_cnt_nxt   = 4'd0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_owner      <= OWN_IF;
            r_last_owner <= OWN_IF;
            r_mem_we     <= 1'b0;
            r_mem_be     <= 4'h0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_ls_win) begin
                r_owner      <= OWN_LS;
                r_last_owner <= OWN_LS;
                r_mem_we     <= ls_we_i;
                r_mem_be     <= ls_be_i;
                r_mem_addr   <= ls_addr_i;
                r_mem_wdata  <= ls_wdata_i;
            end else if (w_if_win) begin
                r_owner      <= OWN_IF;
                r_last_owner <= OWN_IF;
                r_mem_we     <= 1'b0;
                r_mem_be     <= 4'hF;
                r_mem_addr   <= if_addr_i;
                r_mem_wdata  <= 32'h0;
            end
        end
    end

    assign if_gnt_o    = w_if_win;
    assign ls_gnt_o    = w_ls_win;
    assign if_rvalid_o = (r_state == S_RESP) && (r_owner == OWN_IF);
    assign ls_rvalid_o = (r_state == S_RESP) && (r_owner == OWN_LS);
    assign rdata_o     = mem_rdata_i;
    assign mem_req_o   = (r_state == S_ISSUE);
    assign mem_we_o    = r_mem_we;
    assign mem_be_o    = r_mem_be;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three configurations (RR/L=2, fixed-priority/L=2, RR/L=1), directed
// scenarios plus random traffic, all checked against a transaction-timing model and a reference memory.
module tb_mem_port_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic        reset    [N];
    logic        if_req   [N];
    logic [31:0] if_addr  [N];
    logic        if_gnt   [N];
    logic        if_rvalid[N];
    logic        ls_req   [N];
    logic        ls_we    [N];
    logic [3:0]  ls_be    [N];
    logic [31:0] ls_addr  [N];
    logic [31:0] ls_wdata [N];
    logic        ls_gnt   [N];
    logic        ls_rvalid[N];
    logic [31:0] rdata    [N];
    logic        mem_req  [N];
    logic        mem_we   [N];
    logic [3:0]  mem_be   [N];
    logic [31:0] mem_addr [N];
    logic [31:0] mem_wdata[N];
    logic        busy     [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Power-on content of every memory word not yet written.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LAT  = (g == 2) ? 1 : 2;
        localparam int MODE = (g == 1) ? 1 : 0;

        logic [31:0] mem_rdata;

        mem_port_arbiter #(.AW(32), .LATENCY(LAT), .ARB_MODE(MODE)) u_dut (
            .clk        (clk),
            .reset      (reset[g]),
            .if_req_i   (if_req[g]),
            .if_addr_i  (if_addr[g]),
            .if_gnt_o   (if_gnt[g]),
            .if_rvalid_o(if_rvalid[g]),
            .ls_req_i   (ls_req[g]),
            .ls_we_i    (ls_we[g]),
            .ls_be_i    (ls_be[g]),
            .ls_addr_i  (ls_addr[g]),
            .ls_wdata_i (ls_wdata[g]),
            .ls_gnt_o   (ls_gnt[g]),
            .ls_rvalid_o(ls_rvalid[g]),
            .rdata_o    (rdata[g]),
            .mem_req_o  (mem_req[g]),
            .mem_we_o   (mem_we[g]),
            .mem_be_o   (mem_be[g]),
            .mem_addr_o (mem_addr[g]),
            .mem_wdata_o(mem_wdata[g]),
            .mem_rdata_i(mem_rdata),
            .busy_o     (busy[g])
        );

        // Physical memory behind the DUT's bus: answers LAT cycles after a strobe, garbage otherwise.
        logic [31:0] phys [logic [31:0]];
        int          mem_cd   = 0;
        logic [31:0] mem_rd_q = 32'h0;

        always begin
            logic [31:0] w;
            @(posedge clk);
            #1;
            mem_rdata = (mem_cd == 1) ? mem_rd_q : $urandom;
            if (mem_cd > 0) mem_cd--;
            @(negedge clk);
            if (mem_req[g] === 1'b1) begin
                w = phys.exists(mem_addr[g]) ? phys[mem_addr[g]] : init_word(mem_addr[g]);
                if (mem_we[g] === 1'b1) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be[g][b]) w[8*b +: 8] = mem_wdata[g][8*b +: 8];
                    phys[mem_addr[g]] = w;
                end
                mem_rd_q = w;
                mem_cd   = LAT;
            end
        end

        // Reference model: a transaction is tracked by cycles elapsed since its grant
        // (strobe at +1, response at +LAT+1, free again at +LAT+2).
        int          t_since = 0;
        bit          armed   = 1'b0;
        bit          own_ls  = 1'b0;
        bit          last_ls = 1'b0;
        logic        c_we    = 1'b0;
        logic [3:0]  c_be    = 4'h0;
        logic [31:0] c_addr  = 32'h0;
        logic [31:0] c_wdata = 32'h0;
        logic [31:0] ref_mem [logic [31:0]];

        always @(negedge clk) begin : model
            bit          idle;
            bit          win_ls;
            bit          win_if;
            bit          rv_now;
            logic [31:0] w;
            string       p;
            p      = $sformatf("d%0d ", g);
            idle   = (t_since == 0);
            win_ls = idle && !reset[g] && ls_req[g] && (!if_req[g] || MODE == 1 || !last_ls);
            win_if = idle && !reset[g] && if_req[g] && !win_ls;
            rv_now = (t_since == LAT + 1);
            if (armed) begin
                check({p, "if_gnt"},    if_gnt[g],    win_if);
                check({p, "ls_gnt"},    ls_gnt[g],    win_ls);
                check({p, "mem_req"},   mem_req[g],   t_since == 1);
                check({p, "busy"},      busy[g],      !idle);
                check({p, "if_rvalid"}, if_rvalid[g], rv_now && !own_ls);
                check({p, "ls_rvalid"}, ls_rvalid[g], rv_now && own_ls);
                check({p, "mem_we"},    mem_we[g],    c_we);
                check({p, "mem_be"},    mem_be[g],    c_be);
                check({p, "mem_addr"},  mem_addr[g],  c_addr);
                check({p, "mem_wdata"}, mem_wdata[g], c_wdata);
                check({p, "rdata_o"},   rdata[g],     mem_rdata);
                if (rv_now && !c_we) begin
                    w = ref_mem.exists(c_addr) ? ref_mem[c_addr] : init_word(c_addr);
                    check({p, "read data"}, rdata[g], w);
                end
            end
            if (t_since == 1 && own_ls && c_we) begin
                w = ref_mem.exists(c_addr) ? ref_mem[c_addr] : init_word(c_addr);
                for (int b = 0; b < 4; b++)
                    if (c_be[b]) w[8*b +: 8] = c_wdata[8*b +: 8];
                ref_mem[c_addr] = w;
            end
            if (reset[g]) begin
                t_since = 0;
                last_ls = 1'b0;
                c_we    = 1'b0;
                c_be    = 4'h0;
                c_addr  = 32'h0;
                c_wdata = 32'h0;
                armed   = 1'b1;
            end else if (idle) begin
                if (win_ls) begin
                    own_ls  = 1'b1;
                    last_ls = 1'b1;
                    c_we    = ls_we[g];
                    c_be    = ls_be[g];
                    c_addr  = ls_addr[g];
                    c_wdata = ls_wdata[g];
                    t_since = 1;
                end else if (win_if) begin
                    own_ls  = 1'b0;
                    last_ls = 1'b0;
                    c_we    = 1'b0;
                    c_be    = 4'hF;
                    c_addr  = if_addr[g];
                    c_wdata = 32'h0;
                    t_since = 1;
                end
            end else if (t_since == LAT + 1) begin
                t_since = 0;
            end else begin
                t_since++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < N; k++) begin
            if_req[k]   = 1'b0;
            if_addr[k]  = 32'h0;
            ls_req[k]   = 1'b0;
            ls_we[k]    = 1'b0;
            ls_be[k]    = 4'h0;
            ls_addr[k]  = 32'h0;
            ls_wdata[k] = 32'h0;
        end
    endtask

    bit seen_if [N];
    bit seen_ls [N];

    initial begin
        clear_inputs();
        for (int k = 0; k < N; k++) reset[k] = 1'b1;
        tick();
        tick();
        for (int k = 0; k < N; k++) reset[k] = 1'b0;

        // Reset state, no requests pending.
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check("rst busy",     busy[k],     1'b0);
            check("rst mem_req",  mem_req[k],  1'b0);
            check("rst mem_addr", mem_addr[k], 32'h0);
            check("rst mem_be",   mem_be[k],   4'h0);
        end
        tick();

        // Lone IF read of 0x100, LATENCY=2.
        if_req[0] = 1'b1; if_addr[0] = 32'h100;
        @(negedge clk);
        check("t1 if_gnt", if_gnt[0], 1'b1);
        check("t1 ls_gnt", ls_gnt[0], 1'b0);
        tick();
        if_req[0] = 1'b0;
        @(negedge clk);
        check("t1 mem_req",  mem_req[0],  1'b1);
        check("t1 mem_addr", mem_addr[0], 32'h100);
        check("t1 mem_be",   mem_be[0],   4'hF);
        check("t1 mem_we",   mem_we[0],   1'b0);
        tick();
        @(negedge clk);
        check("t1 early rvalid", if_rvalid[0], 1'b0);
        tick();
        @(negedge clk);
        check("t1 if_rvalid", if_rvalid[0], 1'b1);
        check("t1 rdata",     rdata[0],     init_word(32'h100));
        tick();

        // LS partial write, then read it back.
        ls_req[0] = 1'b1; ls_we[0] = 1'b1; ls_be[0] = 4'b0011;
        ls_addr[0] = 32'h2004; ls_wdata[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t4 ls_gnt", ls_gnt[0], 1'b1);
        tick();
        ls_req[0] = 1'b0;
        @(negedge clk);
        check("t4 mem_we",    mem_we[0],    1'b1);
        check("t4 mem_be",    mem_be[0],    4'h3);
        check("t4 mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);
        check("t4 mem_addr",  mem_addr[0],  32'h2004);
        tick();
        tick();
        @(negedge clk);
        check("t4 ls_rvalid", ls_rvalid[0], 1'b1);
        check("t4 if_rvalid", if_rvalid[0], 1'b0);
        tick();
        ls_req[0] = 1'b1; ls_we[0] = 1'b0; ls_be[0] = 4'hF;
        @(negedge clk);
        check("t4 rd ls_gnt", ls_gnt[0], 1'b1);
        tick();
        ls_req[0] = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("t4 rd ls_rvalid", ls_rvalid[0], 1'b1);
        check("t4 rd data", rdata[0], (init_word(32'h2004) & 32'hFFFF_0000) | 32'h0000_BEEF);
        tick();

        // Round-robin from reset with both requests held: LS, IF, LS, IF every 4 cycles.
        reset[0] = 1'b1;
        tick();
        reset[0] = 1'b0;
        if_req[0] = 1'b1; if_addr[0] = 32'h40;
        ls_req[0] = 1'b1; ls_we[0] = 1'b0; ls_be[0] = 4'hF; ls_addr[0] = 32'h80;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("t2 ls_gnt c%0d", i), ls_gnt[0], (i % 8) == 0);
            check($sformatf("t2 if_gnt c%0d", i), if_gnt[0], (i % 8) == 4);
            tick();
        end
        if_req[0] = 1'b0; ls_req[0] = 1'b0;
        tick();

        // Reset during WAIT drops the transaction; the next IF read completes normally.
        if_req[0] = 1'b1; if_addr[0] = 32'h300;
        @(negedge clk);
        check("t5 if_gnt", if_gnt[0], 1'b1);
        tick();
        if_req[0] = 1'b0;
        tick();
        reset[0] = 1'b1;
        @(negedge clk);
        check("t5 busy in wait", busy[0], 1'b1);
        tick();
        reset[0] = 1'b0;
        @(negedge clk);
        check("t5 busy after rst", busy[0],      1'b0);
        check("t5 if_rvalid",      if_rvalid[0], 1'b0);
        check("t5 ls_rvalid",      ls_rvalid[0], 1'b0);
        tick();
        if_req[0] = 1'b1; if_addr[0] = 32'h104;
        @(negedge clk);
        check("t5 regnt", if_gnt[0], 1'b1);
        tick();
        if_req[0] = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("t5 if_rvalid2", if_rvalid[0], 1'b1);
        check("t5 rdata",      rdata[0],     init_word(32'h104));
        tick();

        // Fixed priority: LS wins every time while both are held.
        if_req[1] = 1'b1; if_addr[1] = 32'h500;
        ls_req[1] = 1'b1; ls_we[1] = 1'b0; ls_be[1] = 4'hF; ls_addr[1] = 32'h600;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("t3 ls_gnt c%0d", i), ls_gnt[1], (i % 4) == 0);
            check($sformatf("t3 if_gnt c%0d", i), if_gnt[1], 1'b0);
            tick();
        end
        if_req[1] = 1'b0; ls_req[1] = 1'b0;

        // LATENCY=1 back-to-back IF reads: period of 3 cycles.
        if_req[2] = 1'b1; if_addr[2] = 32'h200;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("t6 if_gnt c%0d", i),    if_gnt[2],    (i % 3) == 0);
            check($sformatf("t6 mem_req c%0d", i),   mem_req[2],   (i % 3) == 1);
            check($sformatf("t6 if_rvalid c%0d", i), if_rvalid[2], (i % 3) == 2);
            tick();
        end
        if_req[2] = 1'b0;
        tick();
        tick();

        // Random traffic on all three configurations with occasional resets.
        for (int k = 0; k < N; k++) begin
            seen_if[k] = 1'b0;
            seen_ls[k] = 1'b0;
        end
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < N; k++) begin
                if (seen_if[k]) if_req[k] = 1'b0;
                if (seen_ls[k]) ls_req[k] = 1'b0;
                if (!if_req[k] && $urandom_range(0, 2) == 0) begin
                    if_req[k]  = 1'b1;
                    if_addr[k] = rand_addr();
                end
                if (!ls_req[k] && $urandom_range(0, 2) == 0) begin
                    ls_req[k]   = 1'b1;
                    ls_we[k]    = 1'($urandom_range(0, 1));
                    ls_be[k]    = 4'($urandom);
                    ls_addr[k]  = rand_addr();
                    ls_wdata[k] = $urandom;
                end
                reset[k] = ($urandom_range(0, 79) == 0);
            end
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                seen_if[k] = if_gnt[k];
                seen_ls[k] = ls_gnt[k];
            end
            tick();
        end
        clear_inputs();
        for (int k = 0; k < N; k++) reset[k] = 1'b0;
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
